// File: rtl/shift_serializer.sv
// -----------------------------------------------------------------------------
// shift_serializer
//
// Takes a WIDTH-bit parallel word over a valid/ready handshake and sends it out
// one bit per shift_en-qualified clock on j. It feeds the downstream sequence
// detector. Words can follow each other with no gap: a new word is loaded on the
// same edge that consumes the last bit of the current word.
//
// Parameters
//   WIDTH      parallel word width, 2..32
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   in_data    parallel word to serialize
//   in_valid   in_data is valid
//   in_ready   word is accepted this cycle when in_ready and in_valid are both high
//   shift_en   advance one bit when high, hold everything when low
//   j          serial bit, registered
//   j_valid    j carries a word bit
//   word_done  one-cycle pulse after the last bit of a word has been consumed
//   word_cnt   completed-word counter, wraps from 255 to 0
// -----------------------------------------------------------------------------
module shift_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             j,
    output logic             j_valid,
    output logic             word_done,
    output logic [7:0]       word_cnt
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             j_q, j_d;
    logic             word_done_q, word_done_d;
    logic [7:0]       word_cnt_q, word_cnt_d;
    logic             last_bit_s;
    logic             accept_s;

    // Returns the bit that sits at the output end of the shift register.
    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return v[WIDTH-1];
        end else begin
            return v[0];
        end
    endfunction

    // Moves the shift register one place toward its output end, zero fill.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    // Handshake decode: the last bit is being consumed this cycle, which frees the slot.
    always_comb begin
        last_bit_s = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX) && shift_en;
        in_ready   = (state_q == ST_IDLE) || last_bit_s;
        accept_s   = in_valid && in_ready;
    end

    // Next-state logic for the FSM, the shift register, the bit index and the outputs.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        word_done_d = last_bit_s;
        word_cnt_d  = last_bit_s ? (word_cnt_q + 8'd1) : word_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    sreg_d  = in_data;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (shift_en) begin
                    if (cnt_q == LAST_IDX) begin
                        // Boundary: load the next word on this edge so j has no gap.
                        if (accept_s) begin
                            sreg_d  = in_data;
                            cnt_d   = '0;
                            state_d = ST_SHIFT;
                        end else begin
                            sreg_d  = '0;
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        sreg_d = shift_once(sreg_q);
                        cnt_d  = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                // Unused encoding: fall back to a clean idle state.
                state_d = ST_IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end
        endcase

        // j is registered from the next register contents, so the first bit shows
        // up in the cycle right after the accept edge.
        if (state_d == ST_SHIFT) begin
            j_d = out_bit(sreg_d);
        end else begin
            j_d = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            j_q         <= 1'b0;
            word_done_q <= 1'b0;
            word_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            j_q         <= j_d;
            word_done_q <= word_done_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    // Output drive: everything below is a flop or a direct decode of the state flop.
    always_comb begin
        j         = j_q;
        j_valid   = (state_q == ST_SHIFT);
        word_done = word_done_q;
        word_cnt  = word_cnt_q;
    end

endmodule

// File: tb/tb_shift_serializer.sv
// Testbench for shift_serializer: an MSB-first and an LSB-first instance (WIDTH=8).
// The driver pushes the expected bit stream on every accept; a negedge monitor
// pops and checks j, j_valid, in_ready, word_done and word_cnt every cycle.
module tb_shift_serializer;

    typedef struct {
        logic b;
        logic last;
    } sb_t;

    logic       clk;
    logic       rst;
    logic       shift_en;
    logic [7:0] din [2];
    logic [1:0] vld_w;
    logic [1:0] rdy_w;
    logic [1:0] j_w;
    logic [1:0] jv_w;
    logic [1:0] done_w;
    logic [7:0] cnt_w [2];

    sb_t        sbq [2][$];
    logic [1:0] exp_done;
    logic [7:0] mcnt [2];
    int         n_checks;
    int         n_err;

    shift_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vld_w[0]), .in_ready(rdy_w[0]),
        .shift_en(shift_en), .j(j_w[0]), .j_valid(jv_w[0]), .word_done(done_w[0]),
        .word_cnt(cnt_w[0])
    );

    shift_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(vld_w[1]), .in_ready(rdy_w[1]),
        .shift_en(shift_en), .j(j_w[1]), .j_valid(jv_w[1]), .word_done(done_w[1]),
        .word_cnt(cnt_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[inst %0d] at %0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // Monitor/scoreboard: clears its model on reset, otherwise checks every negedge.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                sbq[k].delete();
                exp_done[k] = 1'b0;
                mcnt[k]     = 8'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic ev;
                sb_t  e;
                ev = (sbq[k].size() != 0);
                check("j_valid", k, 32'(jv_w[k]), 32'(ev));
                check("j", k, 32'(j_w[k]), ev ? 32'(sbq[k][0].b) : 32'd0);
                check("in_ready", k, 32'(rdy_w[k]),
                      32'(!ev || (sbq[k][0].last && shift_en)));
                check("word_done", k, 32'(done_w[k]), 32'(exp_done[k]));
                check("word_cnt", k, 32'(cnt_w[k]), 32'(mcnt[k]));
                if (ev && shift_en) begin
                    e = sbq[k].pop_front();
                    exp_done[k] = e.last;
                    if (e.last) mcnt[k] = mcnt[k] + 8'd1;
                end else begin
                    exp_done[k] = 1'b0;
                end
            end
        end
    end

    // Offers one word; called at posedge+1, returns at posedge+1 after the accept edge.
    task automatic send(input int k, input logic [7:0] d);
        vld_w[k] = 1'b1;
        din[k]   = d;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (rdy_w[k]) begin
                @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    sb_t e;
                    e.b    = (k == 0) ? d[7-i] : d[i];
                    e.last = (i == 7);
                    sbq[k].push_back(e);
                end
                #1;
                vld_w[k] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("accept_timeout", k, 32'd1, 32'd0);
        vld_w[k] = 1'b0;
    endtask

    // Waits until both scoreboards are empty, plus two cycles for word_done/word_cnt.
    task automatic drain();
        for (int t = 0; t < 400; t++) begin
            if (sbq[0].size() == 0 && sbq[1].size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_timeout", 0, 32'(sbq[0].size() + sbq[1].size()), 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Direct checks of all outputs for both instances while or right after reset.
    task automatic check_reset_outputs(input string nm);
        for (int k = 0; k < 2; k++) begin
            check({nm, "_j"}, k, 32'(j_w[k]), 32'd0);
            check({nm, "_j_valid"}, k, 32'(jv_w[k]), 32'd0);
            check({nm, "_word_done"}, k, 32'(done_w[k]), 32'd0);
            check({nm, "_word_cnt"}, k, 32'(cnt_w[k]), 32'd0);
            check({nm, "_in_ready"}, k, 32'(rdy_w[k]), 32'd1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b1;
        shift_en = 1'b1;
        vld_w    = 2'b00;
        din[0]   = 8'h00;
        din[1]   = 8'h00;
        #12;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single word, MSB first: 1,0,1,1,0,0,0,0 then word_done, word_cnt=1.
        send(0, 8'hB0);
        drain();
        check("single_cnt", 0, 32'(cnt_w[0]), 32'd1);

        // Back-to-back words with in_valid held through the boundary.
        send(0, 8'hB0);
        send(0, 8'h0B);
        drain();
        check("b2b_cnt", 0, 32'(cnt_w[0]), 32'd3);

        // Stall for 3 cycles while the third bit (a 1) is on j.
        send(0, 8'hB0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        shift_en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        shift_en = 1'b1;
        drain();
        check("stall_cnt", 0, 32'(cnt_w[0]), 32'd4);

        // LSB first: 0x0D goes out as 1,0,1,1,0,0,0,0.
        send(1, 8'h0D);
        drain();
        check("lsb_cnt", 1, 32'(cnt_w[1]), 32'd1);

        // Asynchronous reset in the middle of a word, between clock edges.
        send(0, 8'hA5);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        #1;
        rst = 1'b0;
        drain();
        check("midreset_cnt_after", 0, 32'(cnt_w[0]), 32'd0);

        // 256 back-to-back words: the counter wraps back to 0.
        for (int i = 0; i < 256; i++) begin
            send(0, 8'(i) ^ 8'h5A);
        end
        drain();
        check("wrap_cnt", 0, 32'(cnt_w[0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
